// File: rtl/limn2600_mem_pkg.sv
// Shared types and defaults for the Limn2600 memory arbiter.
package limn2600_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

    localparam int DEFAULT_MAX_WAIT   = 15;
    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/limn2600_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a conflict goes to the port that was not granted last.
module limn2600_rr_arb2
    import limn2600_mem_pkg::*;
(
    input  logic  req_i,
    input  logic  req_d,
    input  port_t last,
    output port_t grant,
    output logic  valid
);

    always_comb begin
        valid = req_i | req_d;
        grant = PORT_I;
        if (req_i && req_d) begin
            grant = (last == PORT_I) ? PORT_D : PORT_I;
        end else if (req_d) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/limn2600_mem_arbiter.sv
// Shares the single SRAM bank between the instruction-fetch and data ports:
// round-robin grant, one cs cycle, wait for rdy (with timeout), one-cycle ack.
//
// state | meaning
// IDLE  | no access in flight; grant and latch a request if any
// ISSUE | mem_cs high for exactly this cycle
// WAIT  | waiting for mem_rdy or the timeout count
// RESP  | ack/rdata/err driven to the granted port
module limn2600_mem_arbiter
    import limn2600_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_WAIT   = DEFAULT_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_err,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,

    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdy
);

    localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    arb_state_t            state;
    arb_state_t            state_nxt;
    port_t                 last_grant;
    port_t                 pick_grant;
    logic                  pick_valid;
    logic                  load;

    logic [31:0]           addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt;
    logic                  timeout;
    logic                  resp;

    limn2600_rr_arb2 u_arb (
        .req_i (i_req),
        .req_d (d_req),
        .last  (last_grant),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    assign timeout = (cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            // rdy wins over a simultaneous timeout
            WAIT: begin
                if (mem_rdy || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= PORT_I;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            state <= state_nxt;

            if (load) begin
                last_grant <= pick_grant;
                addr_q     <= (pick_grant == PORT_D) ? d_addr : i_addr;
                we_q       <= (pick_grant == PORT_D) && d_we;
                wdata_q    <= (pick_grant == PORT_D) ? d_wdata : '0;
            end

            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT && !mem_rdy && !timeout) begin
                cnt <= cnt + 1'b1;
            end

            if (state == WAIT) begin
                if (mem_rdy) begin
                    rdata_q <= we_q ? '0 : mem_rdata;
                    err_q   <= 1'b0;
                end else if (timeout) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign resp = (state == RESP);

    assign i_ack   = resp && (last_grant == PORT_I);
    assign i_rdata = i_ack ? rdata_q : '0;
    assign i_err   = i_ack && err_q;

    assign d_ack   = resp && (last_grant == PORT_D);
    assign d_rdata = d_ack ? rdata_q : '0;
    assign d_err   = d_ack && err_q;

    assign mem_cs    = (state == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: doc/limn2600_mem_arbiter.md
# limn2600_mem_arbiter

Two-port arbiter that shares the single Limn2600 SRAM bank controller between the CPU instruction-fetch port and the data (load/store) port. It performs round-robin arbitration, registers the winning request, and drives exactly one `cs` cycle to the SRAM. It then waits for `rdy`, returns read data with a one-cycle acknowledge, and reports a bus error if the SRAM never answers. It sits between the CPU core's memory ports and `limn2600_SRAM`.

## Interface
- `DATA_WIDTH`, 32, data bus width; must match the SRAM.
- `MAX_WAIT`, 15, cycles spent in WAIT without `mem_rdy` before a timeout error.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_req`  in  1  instruction fetch request; held until `i_ack`.
- `i_addr`  in  32  fetch address; stable while `i_req`.
- `i_ack`  out  1  one-cycle completion pulse.
- `i_rdata`  out  DATA_WIDTH  fetch data; valid only while `i_ack`.
- `i_err`  out  1  timeout flag; valid only while `i_ack`.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_ack`, `d_rdata`, `d_err`  out  1 / DATA_WIDTH / 1  same rules as the `i_` outputs.
- `mem_cs`, `mem_we`  out  1  to SRAM `cs`, `we`.
- `mem_addr`  out  32  to SRAM `addr`.
- `mem_wdata`  out  DATA_WIDTH  to SRAM `data_in`.
- `mem_rdata`  in  DATA_WIDTH  from SRAM `data_out`.
- `mem_rdy`  in  1  from SRAM `rdy`.

## Operation
- The instruction port is read-only; it always issues `mem_we=0`.
- FSM states:
  - IDLE: if any `req` is asserted, pick a winner, latch addr/we/wdata and grant, then go to ISSUE.
  - ISSUE: `mem_cs=1` for exactly one cycle, then go to WAIT.
  - WAIT: on `mem_rdy`, capture `mem_rdata` and go to RESP. If the wait counter reaches `MAX_WAIT`, set the error flag and go to RESP.
  - RESP: drive `ack`, `rdata` and `err` to the granted port only, then go to IDLE.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting: the port not granted last wins.
  - `last_grant` resets to I, so the first conflict after reset goes to D.
  - `last_grant` updates on every grant.
- `mem_addr`, `mem_we` and `mem_wdata` come from the latch registers and hold from ISSUE through RESP. Requester inputs are never passed through combinationally.
- On a store, `rdata` is 0. On a timeout, `rdata` is 0 and `err` is 1.
- `mem_rdy` is ignored in IDLE, ISSUE and RESP. This covers a stale `rdy` after reset or after a timeout.
- RESP always returns to IDLE. The acked port's `req`, still high during RESP, is never re-granted in that same cycle.
- Wait counter:
  - Width is $clog2(MAX_WAIT+1).
  - Clears on entry to WAIT and increments each WAIT cycle without `rdy`.
  - `rdy` arriving on the cycle the count hits `MAX_WAIT` counts as success; `rdy` takes priority over the timeout.

## Timing
- Reset: state = IDLE, `last_grant` = I, counter = 0. All outputs are 0: `mem_cs`, `mem_we`, `mem_addr`, `mem_wdata`, both acks, both rdatas, both errs.
- Reset during ISSUE/WAIT/RESP abandons the access with no ack. The requester must re-request after reset.
- Latency: `req` high in cycle 0 (IDLE), `mem_cs` in cycle 1, `mem_rdy` in cycle 2, `ack` in cycle 3. One access per 4 cycles is the minimum; with no gap, the next IDLE is cycle 4.
- Timeout path: `ack` with `err` asserted `MAX_WAIT`+2 cycles after ISSUE.
- `ack` is high for exactly one cycle. A requester may drop `req` or change its fields in the cycle after `ack`.
- Requests that arrive in a non-IDLE state wait; no request is ever lost while `req` stays high.

## Structure
- Package `limn2600_mem_pkg` holds:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, RESP};
  - `port_t` enum {PORT_I, PORT_D};
  - `DEFAULT_MAX_WAIT` constant.
- One sub-module, `limn2600_rr_arb2`: a combinational 2-way round-robin picker.
  - Inputs: `req_i`, `req_d`, `last`.
  - Outputs: `grant`, `valid`.
- The FSM, latches and counter live in the top module.

## Test plan
- Reset, then `d_req` store with `addr=0x00000010`, `wdata=0xDEADBEEF`: `mem_cs` high only in cycle 1 with `we=1` and those values; `d_ack` in cycle 3 with `d_err=0`. A follow-up load of `0x10` returns `d_rdata=0xDEADBEEF`.
- `i_req` fetch at `addr=0xFFFE0000`: `mem_we=0`; `i_ack` in cycle 3 with `i_rdata` equal to ROM word 0.
- `i_req` and `d_req` both held from reset: grant order is D, I, D, I over 4 accesses; each ack arrives 4 cycles apart; no ack goes to the wrong port.
- SRAM model with `rdy` tied to 0, `MAX_WAIT=15`: `d_ack` with `d_err=1` and `d_rdata=0` arrives 17 cycles after ISSUE; the FSM then returns to IDLE and serves a pending `i_req` normally.
- Assert `rst` in the WAIT cycle, with the SRAM raising `rdy` the next cycle: no ack is produced, all outputs read 0, and the stray `rdy` is ignored.
- `rdy` delivered on exactly the `MAX_WAIT`-th WAIT cycle: `ack` with `err=0` and the real data.
